// File: rtl/dpi_stream_sequencer_if.sv
// Sequencer bus: upstream byte beats, matcher control and the result handshake.
// The master modport is the environment side; the slave modport is the sequencer.
interface dpi_stream_sequencer_if #(
    parameter int unsigned NUM_MATCHERS = 8,
    parameter int unsigned KEY_W        = 32
);
    logic [7:0]              in_data;
    logic                    in_vld;
    logic                    in_sop;
    logic                    in_eop;
    logic [KEY_W-1:0]        in_flow_key;
    logic                    in_rdy;
    logic [7:0]              char_in;
    logic                    char_in_vld;
    logic                    load_state;
    logic [5:0]              stream_id;
    logic                    new_stream_id;
    logic                    eop;
    logic [NUM_MATCHERS-1:0] fired;
    logic                    res_vld;
    logic                    res_rdy;
    logic [5:0]              res_stream_id;
    logic [NUM_MATCHERS-1:0] res_fired;
    logic [15:0]             res_len;
    logic                    res_err;

    modport master (
        output in_data, in_vld, in_sop, in_eop, in_flow_key, fired, res_rdy,
        input  in_rdy, char_in, char_in_vld, load_state, stream_id, new_stream_id, eop,
               res_vld, res_stream_id, res_fired, res_len, res_err
    );

    modport slave (
        input  in_data, in_vld, in_sop, in_eop, in_flow_key, fired, res_rdy,
        output in_rdy, char_in, char_in_vld, load_state, stream_id, new_stream_id, eop,
               res_vld, res_stream_id, res_fired, res_len, res_err
    );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Packet-to-matcher sequencer: slot lookup, byte streaming, eop and result reporting.
// DPI_SEQ_FLOW_TABLE_EN selects a 64-entry flow key table; otherwise key[5:0] is the slot.
module dpi_stream_sequencer #(
    parameter int unsigned NUM_MATCHERS = 8,
    parameter int unsigned KEY_W        = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    dpi_stream_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StLoad, StWait, StStream, StDrain, StEop, StResult
    } state_e;

    state_e state_q, state_d;

    logic [7:0]              in_data;
    logic                    in_vld, in_sop, in_eop, res_rdy;
    logic [KEY_W-1:0]        in_flow_key;
    logic [NUM_MATCHERS-1:0] fired;

    logic                    in_rdy, accept, start, trunc;
    logic [7:0]              char_q;
    logic                    char_vld_q;
    logic [5:0]              sid_q, res_sid_q;
    logic                    new_q, err_q;
    logic [15:0]             len_q;
    logic [NUM_MATCHERS-1:0] fired_q;
    logic [5:0]              lookup_id;
    logic                    lookup_new;

    assign in_data     = bus.in_data;
    assign in_vld      = bus.in_vld;
    assign in_sop      = bus.in_sop;
    assign in_eop      = bus.in_eop;
    assign in_flow_key = bus.in_flow_key;
    assign fired       = bus.fired;
    assign res_rdy     = bus.res_rdy;

    // WAIT takes the held sop beat, so the first byte reaches the matchers two
    // cycles after load_state while the matchers see one idle cycle.
    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        accept  = 1'b0;
        start   = 1'b0;
        trunc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_vld && in_sop) begin
                    start   = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    accept  = 1'b1;
                    state_d = in_eop ? StDrain : StStream;
                end
            end
            StStream: begin
                if (in_vld && in_sop) begin
                    // Premature sop is left pending; it opens the next packet.
                    trunc   = 1'b1;
                    state_d = StDrain;
                end else begin
                    in_rdy = 1'b1;
                    if (in_vld) begin
                        accept = 1'b1;
                        if (in_eop) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain:  state_d = StEop;
            StEop:    state_d = StResult;
            StResult: begin
                if (res_rdy) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            sid_q      <= '0;
            new_q      <= 1'b0;
            len_q      <= '0;
            err_q      <= 1'b0;
            fired_q    <= '0;
            res_sid_q  <= '0;
        end else begin
            state_q    <= state_d;
            char_vld_q <= accept;
            if (accept) begin
                char_q <= in_data;
            end
            if (start) begin
                sid_q <= lookup_id;
                new_q <= lookup_new;
                len_q <= '0;
                err_q <= 1'b0;
            end else if (accept && (len_q != 16'hFFFF)) begin
                len_q <= len_q + 16'd1;
            end
            if (trunc) begin
                err_q <= 1'b1;
            end
            if (state_q == StEop) begin
                fired_q   <= fired;
                res_sid_q <= sid_q;
            end
        end
    end

`ifdef DPI_SEQ_FLOW_TABLE_EN
    logic [KEY_W-1:0] tbl_key_q [64];
    logic [63:0]      tbl_vld_q;
    logic [5:0]       rr_q;
    logic             hit;
    logic [5:0]       hit_idx;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == in_flow_key)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
        lookup_id  = hit ? hit_idx : rr_q;
        lookup_new = ~hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_vld_q <= '0;
            rr_q      <= '0;
        end else if (start && !hit) begin
            tbl_vld_q[rr_q] <= 1'b1;
            rr_q            <= rr_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start && !hit) begin
            tbl_key_q[rr_q] <= in_flow_key;
        end
    end
`else
    logic [63:0] seen_q;
    logic        unused_key;

    assign unused_key = ^in_flow_key[KEY_W-1:6];

    always_comb begin
        lookup_id  = in_flow_key[5:0];
        lookup_new = ~seen_q[in_flow_key[5:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (start) begin
            seen_q[lookup_id] <= 1'b1;
        end
    end
`endif

    assign bus.in_rdy        = in_rdy;
    assign bus.char_in       = char_q;
    assign bus.char_in_vld   = char_vld_q;
    assign bus.load_state    = (state_q == StLoad);
    assign bus.stream_id     = sid_q;
    assign bus.new_stream_id = new_q;
    assign bus.eop           = (state_q == StEop);
    assign bus.res_vld       = (state_q == StResult);
    assign bus.res_stream_id = res_sid_q;
    assign bus.res_fired     = fired_q;
    assign bus.res_len       = len_q;
    assign bus.res_err       = err_q;
endmodule

// File: doc/dpi_stream_sequencer.md
DPI_STREAM_SEQUENCER -- requirements
Module: dpi_stream_sequencer

Interface
REQ-001 SHALL have parameter NUM_MATCHERS, default 8, giving the width of the matcher fired vector.
REQ-002 SHALL have parameter KEY_W, default 32, giving the flow key width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_data  input  8  upstream payload byte.
REQ-006 in_vld  input  1  upstream beat valid.
REQ-007 in_sop  input  1  first byte of packet.
REQ-008 in_eop  input  1  last byte of packet.
REQ-009 in_flow_key  input  KEY_W  flow key, valid with in_sop.
REQ-010 in_rdy  output  1  beat accepted when in_vld & in_rdy.
REQ-011 char_in  output  8  byte to matchers.
REQ-012 char_in_vld  output  1  char_in valid.
REQ-013 load_state  output  1  one-cycle request to matchers to restore per-stream state.
REQ-014 stream_id  output  6  stream slot index.
REQ-015 new_stream_id  output  1  slot freshly allocated; matchers reset state.
REQ-016 eop  output  1  one-cycle end of packet to matchers.
REQ-017 fired  input  NUM_MATCHERS  per-matcher match flags.
REQ-018 res_vld / res_rdy  output / input  1 / 1  result handshake.
REQ-019 res_stream_id  output  6  slot of reported packet.
REQ-020 res_fired  output  NUM_MATCHERS  fired sampled at eop.
REQ-021 res_len  output  16  packet byte count, saturating at 16'hFFFF.
REQ-022 res_err  output  1  packet truncated by a premature in_sop.

Function
REQ-023 FSM states SHALL be IDLE, LOAD, WAIT, STREAM, DRAIN, EOP, RESULT.
REQ-024 IDLE: in_rdy=0; on in_vld & in_sop, latch key, perform slot lookup, go to LOAD; sop beat is not consumed yet.
REQ-025 Lookup: 64-entry key table; a hit gives stream_id=index with new_stream_id=0; a miss writes key at round-robin pointer, gives stream_id=pointer with new_stream_id=1, and advances the pointer (63 wraps to 0).
REQ-026 LOAD: load_state=1 for exactly one cycle; stream_id and new_stream_id valid the same cycle; go to WAIT.
REQ-027 WAIT: one idle cycle; first char_in_vld occurs 2 cycles after load_state.
REQ-028 STREAM: in_rdy=1; each accepted beat drives char_in=in_data, char_in_vld=1 on the next cycle; in_vld gaps give char_in_vld=0; res_len increments per byte.
REQ-029 Accepted beat with in_eop goes to DRAIN; a single-beat packet (sop & eop) is legal, with length 1.
REQ-030 In STREAM, in_vld & in_sop before in_eop: in_rdy=0 that cycle (beat kept), res_err=1, go to DRAIN.
REQ-031 DRAIN: one cycle for the last matcher accept to register; then EOP.
REQ-032 EOP: eop=1 for one cycle; res_fired samples fired that cycle; go to RESULT.
REQ-033 stream_id SHALL stay constant from LOAD through EOP inclusive.
REQ-034 RESULT: res_vld=1 with stable res_* until res_rdy; then IDLE.
REQ-035 load_state, eop and char_in_vld SHALL never assert in the same cycle.

Reset
REQ-036 On rst_n=0: state=IDLE; in_rdy, char_in_vld, load_state, eop, new_stream_id, res_vld, res_err=0; stream_id, char_in, res_len, res_fired, res_stream_id=0; all table valid bits and round-robin pointer=0; reset mid-packet abandons the packet with no eop.

Configuration
REQ-037 Macro DPI_SEQ_FLOW_TABLE_EN defined: key table lookup per REQ-025.
REQ-038 Macro DPI_SEQ_FLOW_TABLE_EN undefined: no key table; stream_id=in_flow_key[5:0]; new_stream_id=1 on the first use of that id since reset, else 0, tracked in a 64-bit seen vector.

Verification
REQ-039 Reset, then key 0x11 with 3-byte packet "abc" -> load_state with stream_id=0 and new_stream_id=1; chars 2,3,4 cycles later; eop after DRAIN; res_len=3.
REQ-040 Key 0x11 again -> stream_id=0, new_stream_id=0; key 0x22 -> stream_id=1, new_stream_id=1.
REQ-041 65 distinct keys -> 65th gets stream_id=0 with new_stream_id=1; reusing the first key is then a miss.
REQ-042 fired=8'h05 driven during the eop cycle -> res_fired=8'h05; res_rdy held low 10 cycles -> res_vld and data held, in_rdy=0.
REQ-043 in_sop at byte 2 of an unterminated packet -> res_err=1, res_len=2; next packet starts from that sop beat.
REQ-044 Single-byte packet, then rst_n low during STREAM of a 100-byte packet -> no eop after reset; all outputs at reset values.
